// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment driver.
// Glyphs are active-high {dp,g,f,e,d,c,b,a}. Output polarity is applied
// only at the driver's output register.
package seg_pkg;

   localparam logic [7:0] GLYPH_DIGIT [10] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
      8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
   };
   localparam logic [7:0] GLYPH_MINUS = 8'h40;
   localparam logic [7:0] GLYPH_BLANK = 8'h00;
   localparam logic [7:0] GLYPH_DP    = 8'h80;

   typedef enum logic [1:0] {GS_DIGIT, GS_MINUS, GS_BLANK} glyph_sel_t;

   typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_COMMIT} cv_state_t;

   // Non-decimal nibbles cannot come out of the converter; blank them anyway.
   function automatic logic [7:0] digit_glyph(input logic [3:0] nib);
      if (nib < 4'd10) return GLYPH_DIGIT[nib];
      return GLYPH_BLANK;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter with a one-deep pending slot.
// Ports:
//   sys_clk, sys_rst  clock, synchronous active-high reset
//   data, data_vld    value and start strobe (accepted at any time)
//   busy              conversion in progress
//   bcd, ovf          committed result; changes atomically, never partial
//
// state     | meaning
// CV_IDLE   | waiting for data_vld
// CV_SHIFT  | one add-3/shift iteration per cycle, DATA_W cycles
// CV_COMMIT | publish result, or restart at once on a newer value
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int DIGITS = 6,
   parameter int DATA_W = 20
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic [DATA_W-1:0]     data,
   input  logic                  data_vld,
   output logic                  busy,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int BCD_W = 4*DIGITS;
   localparam int CNT_W = $clog2(DATA_W+1);
   localparam logic [31:0] OVF_LIM = 32'(10**DIGITS);

   cv_state_t state, state_nxt;
   logic [DATA_W-1:0] bin_q, pend_data, load_data;
   logic [BCD_W-1:0]  acc_q, acc_adj;
   logic [CNT_W-1:0]  iter_cnt;
   logic              ovf_q, pend_q, load;

   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
   end

   // A newer value arriving while busy supersedes the one in flight: the
   // in-flight result is dropped at COMMIT instead of being shown briefly.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      load_data = data;
      case (state)
         CV_IDLE: begin
            if (data_vld) begin
               load      = 1'b1;
               state_nxt = CV_SHIFT;
            end
         end
         CV_SHIFT: begin
            if (iter_cnt == '0) state_nxt = CV_COMMIT;
         end
         CV_COMMIT: begin
            if (data_vld || pend_q) begin
               load      = 1'b1;
               load_data = data_vld ? data : pend_data;
               state_nxt = CV_SHIFT;
            end else begin
               state_nxt = CV_IDLE;
            end
         end
         default: state_nxt = CV_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state     <= CV_IDLE;
         bin_q     <= '0;
         acc_q     <= '0;
         iter_cnt  <= '0;
         ovf_q     <= 1'b0;
         pend_q    <= 1'b0;
         pend_data <= '0;
         bcd       <= '0;
         ovf       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) begin
            bin_q    <= load_data;
            acc_q    <= '0;
            ovf_q    <= 32'(load_data) >= OVF_LIM;
            iter_cnt <= CNT_W'(DATA_W-1);
         end else if (state == CV_SHIFT) begin
            {acc_q, bin_q} <= {acc_adj, bin_q} << 1;
            if (iter_cnt != '0) iter_cnt <= iter_cnt - 1'b1;
         end
         if (load) begin
            pend_q <= 1'b0;
         end else if (busy && data_vld) begin
            pend_q    <= 1'b1;
            pend_data <= data;
         end
         if (state == CV_COMMIT && !load) begin
            bcd <= acc_q;
            ovf <= ovf_q;
         end
      end
   end

   assign busy = (state != CV_IDLE);

endmodule

// File: rtl/seg_dynamic_param.sv
// Time-multiplexed 7-segment driver with BCD conversion, leading-zero
// blanking, sign, decimal points, blink and overflow dashes.
// Ports:
//   sys_clk, sys_rst   clock, synchronous active-high reset
//   data, data_vld     value to display and its load strobe
//   point, sign, blink per-digit dp, minus sign, per-digit blink (live)
//   seg_en             display enable (live)
//   busy               conversion in progress
//   sel                one-hot digit select, polarity per SEL_ACT_LOW
//   seg                {dp,g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
module seg_dynamic_param
   import seg_pkg::*;
#(
   parameter int DIGITS      = 6,
   parameter int DATA_W      = 20,
   parameter int SCAN_CNT    = 50000,
   parameter int BLINK_TICKS = 250,
   parameter bit SEG_ACT_LOW = 1'b1,
   parameter bit SEL_ACT_LOW = 1'b0
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [DATA_W-1:0] data,
   input  logic              data_vld,
   input  logic [DIGITS-1:0] point,
   input  logic              sign,
   input  logic [DIGITS-1:0] blink,
   input  logic              seg_en,
   output logic              busy,
   output logic [DIGITS-1:0] sel,
   output logic [7:0]        seg
);

   localparam int SCAN_W = $clog2(SCAN_CNT);
   localparam int BLK_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int IDX_W  = $clog2(DIGITS);

   logic [4*DIGITS-1:0] disp_bcd;
   logic                disp_ovf;
   logic [SCAN_W-1:0]   scan_cnt;
   logic [BLK_W-1:0]    blink_cnt;
   logic [IDX_W-1:0]    idx, msd;
   logic                tick, blink_ph;
   glyph_sel_t          gsel;
   logic [7:0]          seg_raw;
   logic [DIGITS-1:0]   sel_raw;

   bin2bcd_seq #(.DIGITS(DIGITS), .DATA_W(DATA_W)) u_conv (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .data     (data),
      .data_vld (data_vld),
      .busy     (busy),
      .bcd      (disp_bcd),
      .ovf      (disp_ovf)
   );

   assign tick = (scan_cnt == '0);

   // Most significant digit that must be shown: a set decimal point keeps
   // its zero digit visible.
   always_comb begin
      msd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (disp_bcd[4*i +: 4] != 4'd0 || point[i]) msd = IDX_W'(i);
      end
   end

   always_comb begin
      gsel = GS_DIGIT;
      if (disp_ovf)                gsel = GS_MINUS;
      else if (blink[idx] && blink_ph) gsel = GS_BLANK;
      else if (idx > msd)          gsel = (sign && idx == msd + 1'b1) ? GS_MINUS : GS_BLANK;

      case (gsel)
         GS_DIGIT: seg_raw = digit_glyph(disp_bcd[{idx, 2'b00} +: 4])
                             | (point[idx] ? GLYPH_DP : GLYPH_BLANK);
         GS_MINUS: seg_raw = GLYPH_MINUS;
         default:  seg_raw = GLYPH_BLANK;
      endcase
      sel_raw = DIGITS'(1) << idx;

      if (!seg_en) begin
         seg_raw = GLYPH_BLANK;
         sel_raw = '0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         scan_cnt  <= SCAN_W'(SCAN_CNT-1);
         blink_cnt <= BLK_W'(BLINK_TICKS-1);
         blink_ph  <= 1'b0;
         idx       <= '0;
         sel       <= SEL_ACT_LOW ? '1 : '0;
         seg       <= SEG_ACT_LOW ? 8'hFF : 8'h00;
      end else begin
         scan_cnt <= tick ? SCAN_W'(SCAN_CNT-1) : scan_cnt - 1'b1;
         if (tick) begin
            idx <= (idx == IDX_W'(DIGITS-1)) ? '0 : idx + 1'b1;
            if (blink_cnt == '0) begin
               blink_cnt <= BLK_W'(BLINK_TICKS-1);
               blink_ph  <= ~blink_ph;
            end else begin
               blink_cnt <= blink_cnt - 1'b1;
            end
            sel <= SEL_ACT_LOW ? ~sel_raw : sel_raw;
            seg <= SEG_ACT_LOW ? ~seg_raw : seg_raw;
         end
      end
   end

endmodule

// File: tb/tb_seg_dynamic_param.sv
module tb_seg_dynamic_param;

   localparam int DIGITS      = 6;
   localparam int DATA_W      = 20;
   localparam int SCAN_CNT    = 4;
   localparam int BLINK_TICKS = 2;

   logic              sys_clk = 1'b0;
   logic              sys_rst = 1'b1;
   logic [DATA_W-1:0] data = '0;
   logic              data_vld = 1'b0;
   logic [DIGITS-1:0] point = '0;
   logic              sign = 1'b0;
   logic [DIGITS-1:0] blink = '0;
   logic              seg_en = 1'b1;
   logic              busy;
   logic [DIGITS-1:0] sel;
   logic [7:0]        seg;

   int vectors = 0;
   int errors  = 0;
   logic [7:0] frame [DIGITS];

   always #5 sys_clk = ~sys_clk;

   seg_dynamic_param #(
      .DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_CNT(SCAN_CNT),
      .BLINK_TICKS(BLINK_TICKS), .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b0)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .data(data), .data_vld(data_vld),
      .point(point), .sign(sign), .blink(blink), .seg_en(seg_en),
      .busy(busy), .sel(sel), .seg(seg)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic send(input logic [DATA_W-1:0] v);
      data     = v;
      data_vld = 1'b1;
      step(1);
      data_vld = 1'b0;
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 200 && busy !== 1'b0; c++) step(1);
      vectors++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: busy=%b required=0", busy);
      end
   endtask

   // Records one full scan; only slots selected after the call are taken.
   task automatic capture();
      logic [DIGITS-1:0] prev, seen;
      prev = sel;
      seen = '0;
      for (int c = 0; c < 400 && seen != '1; c++) begin
         step(1);
         if (sel !== prev) begin
            for (int i = 0; i < DIGITS; i++)
               if (sel === DIGITS'(1 << i)) begin
                  frame[i] = seg;
                  seen[i]  = 1'b1;
               end
            prev = sel;
         end
      end
      vectors++;
      if (seen != '1) begin
         errors++;
         $display("FAIL capture: digits seen=%b required=111111", seen);
      end
   endtask

   task automatic test_reset();
      logic [7:0] want [DIGITS];
      sys_rst = 1'b1;
      step(3);
      vectors += 3;
      if (seg !== 8'hFF)  begin errors++; $display("FAIL reset_seg: got=%h required=ff", seg); end
      if (sel !== 6'h00)  begin errors++; $display("FAIL reset_sel: got=%b required=000000", sel); end
      if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got=%b required=0", busy); end
      sys_rst = 1'b0;
      capture();
      want = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      for (int i = 0; i < DIGITS; i++) begin
         vectors++;
         if (frame[i] !== want[i]) begin
            errors++;
            $display("FAIL reset_digit%0d: got=%h required=%h", i, frame[i], want[i]);
         end
      end
   endtask

   task automatic test_convert();
      logic [7:0] want [DIGITS];
      logic [DIGITS-1:0] prev;
      int n, changes, last;
      send(20'd123456);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         step(1);
      end
      vectors++;
      if (n != 21) begin errors++; $display("FAIL convert_busy_len: got=%0d required=21", n); end
      capture();
      want = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
      for (int i = 0; i < DIGITS; i++) begin
         vectors++;
         if (frame[i] !== want[i]) begin
            errors++;
            $display("FAIL convert_digit%0d: got=%h required=%h", i, frame[i], want[i]);
         end
      end
      prev = sel;
      changes = 0;
      last = 0;
      for (int c = 1; c < 200 && changes < 7; c++) begin
         step(1);
         if (sel !== prev) begin
            if (changes > 0) begin
               vectors += 2;
               if (c - last != SCAN_CNT) begin
                  errors++;
                  $display("FAIL scan_period: got=%0d required=%0d", c - last, SCAN_CNT);
               end
               if (sel !== {prev[DIGITS-2:0], prev[DIGITS-1]}) begin
                  errors++;
                  $display("FAIL scan_order: got=%b required=%b", sel, {prev[DIGITS-2:0], prev[DIGITS-1]});
               end
            end
            last = c;
            prev = sel;
            changes++;
         end
      end
      vectors++;
      if (changes < 7) begin errors++; $display("FAIL scan_steps: got=%0d required=7", changes); end
   endtask

   task automatic test_sign();
      logic [7:0] want [DIGITS];
      sign  = 1'b1;
      point = '0;
      send(20'd42);
      wait_idle();
      capture();
      want = '{8'hA4, 8'h99, 8'hBF, 8'hFF, 8'hFF, 8'hFF};
      for (int i = 0; i < DIGITS; i++) begin
         vectors++;
         if (frame[i] !== want[i]) begin
            errors++;
            $display("FAIL sign_digit%0d: got=%h required=%h", i, frame[i], want[i]);
         end
      end
      sign = 1'b0;
   endtask

   task automatic test_point_ovf();
      logic [7:0] want [DIGITS];
      point = 6'b000100;
      send(20'd5);
      wait_idle();
      capture();
      want = '{8'h92, 8'hC0, 8'h40, 8'hFF, 8'hFF, 8'hFF};
      for (int i = 0; i < DIGITS; i++) begin
         vectors++;
         if (frame[i] !== want[i]) begin
            errors++;
            $display("FAIL point_digit%0d: got=%h required=%h", i, frame[i], want[i]);
         end
      end
      point = '0;
      send(20'd999999);
      wait_idle();
      capture();
      for (int i = 0; i < DIGITS; i++) begin
         vectors++;
         if (frame[i] !== 8'h90) begin
            errors++;
            $display("FAIL max_digit%0d: got=%h required=90", i, frame[i]);
         end
      end
      send(20'd1000000);
      wait_idle();
      capture();
      for (int i = 0; i < DIGITS; i++) begin
         vectors++;
         if (frame[i] !== 8'hBF) begin
            errors++;
            $display("FAIL ovf_digit%0d: got=%h required=bf", i, frame[i]);
         end
      end
   endtask

   task automatic test_enable();
      seg_en = 1'b0;
      step(2*SCAN_CNT);
      vectors += 2;
      if (sel !== 6'h00) begin errors++; $display("FAIL disable_sel: got=%b required=000000", sel); end
      if (seg !== 8'hFF) begin errors++; $display("FAIL disable_seg: got=%h required=ff", seg); end
      seg_en = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [7:0] want [DIGITS];
      int n;
      logic bad;
      sys_rst = 1'b1;
      step(1);
      sys_rst = 1'b0;
      send(20'd111);
      n = 0;
      bad = 1'b0;
      if (busy === 1'b1) n++;
      step(1);
      if (busy === 1'b1) n++;
      send(20'd222);
      while (busy === 1'b1 && n < 200) begin
         n++;
         if (sel === 6'b000001 && seg !== 8'hC0) bad = 1'b1;
         if (sel !== 6'b000001 && sel !== 6'h00 && seg !== 8'hFF) bad = 1'b1;
         step(1);
      end
      vectors += 2;
      if (n != 42) begin errors++; $display("FAIL b2b_busy_len: got=%0d required=42", n); end
      if (bad)     begin errors++; $display("FAIL b2b_intermediate: got=changed display required=0 until 222"); end
      capture();
      want = '{8'hA4, 8'hA4, 8'hA4, 8'hFF, 8'hFF, 8'hFF};
      for (int i = 0; i < DIGITS; i++) begin
         vectors++;
         if (frame[i] !== want[i]) begin
            errors++;
            $display("FAIL b2b_digit%0d: got=%h required=%h", i, frame[i], want[i]);
         end
      end
   endtask

   task automatic test_blink();
      logic [7:0] v [4];
      logic [DIGITS-1:0] prev;
      logic other_bad;
      int k;
      blink = 6'b000001;
      send(20'd7);
      wait_idle();
      prev = sel;
      k = 0;
      other_bad = 1'b0;
      for (int c = 0; c < 600 && k < 4; c++) begin
         step(1);
         if (sel !== prev) begin
            if (sel === 6'b000001) begin
               v[k] = seg;
               k++;
            end else if (seg !== 8'hFF) begin
               other_bad = 1'b1;
            end
            prev = sel;
         end
      end
      vectors += 2;
      if (k != 4)    begin errors++; $display("FAIL blink_visits: got=%0d required=4", k); end
      if (other_bad) begin errors++; $display("FAIL blink_others: got=lit required=ff"); end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (v[i] !== 8'hF8 && v[i] !== 8'hFF) begin
            errors++;
            $display("FAIL blink_glyph%0d: got=%h required=f8 or ff", i, v[i]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (v[i] === v[i+1]) begin
            errors++;
            $display("FAIL blink_toggle%0d: got=%h twice required=alternating", i, v[i]);
         end
      end
      blink = '0;
   endtask

   task automatic test_reset_mid();
      logic [7:0] want [DIGITS];
      send(20'd555);
      step(3);
      send(20'd777);
      step(2);
      sys_rst = 1'b1;
      step(1);
      vectors += 3;
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got=%b required=0", busy); end
      if (seg !== 8'hFF) begin errors++; $display("FAIL midrst_seg: got=%h required=ff", seg); end
      if (sel !== 6'h00) begin errors++; $display("FAIL midrst_sel: got=%b required=000000", sel); end
      sys_rst = 1'b0;
      step(30);
      vectors++;
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_pending: got busy=%b required=0", busy); end
      capture();
      want = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      for (int i = 0; i < DIGITS; i++) begin
         vectors++;
         if (frame[i] !== want[i]) begin
            errors++;
            $display("FAIL midrst_digit%0d: got=%h required=%h", i, frame[i], want[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_convert();
      test_sign();
      test_point_ovf();
      test_enable();
      test_back_to_back();
      test_blink();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
